// File: rtl/acc_share_ctrl.sv
// acc_share_ctrl
// Round-robin scheduler that lends one burst accumulator to four requesters.
// Each transaction runs IDLE -> LAUNCH -> RUN -> WAIT -> DONE:
//   LAUNCH: one-cycle start pulse to the accumulator,
//   RUN:    acc_num+1 samples streamed from the owner, with a read strobe,
//   WAIT:   the end flag is awaited, with a bounded timeout,
//   DONE:   the sum is handed back to the owner with a done pulse.
//
// Ports
//   sys_clk, sys_rst      clock, asynchronous active-low reset
//   req[3:0]              level request per requester, held until its done
//   num_bus               per-requester sample count (slice i = [i*CNT_W +: CNT_W])
//   data_bus              per-requester data word (slice i = [i*DATA_W +: DATA_W])
//   rd[3:0]               one-hot read strobe to the owner during RUN
//   grant[3:0]            one-hot owner from LAUNCH through DONE
//   done[3:0]             one-cycle completion pulse to the owner
//   result                sum of the last completed transaction
//   busy                  high whenever the FSM is not in IDLE
//   err                   sticky accumulator-timeout flag
//   acc_add_en            start pulse to the accumulator
//   acc_num               sample count to the accumulator
//   acc_data              data to the accumulator (owner's slice)
//   acc_sum, acc_add_end  sum and end flag returned by the accumulator
module acc_share_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4,
  parameter int TO_CYC = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [3:0]          req,
  input  logic [4*CNT_W-1:0]  num_bus,
  input  logic [4*DATA_W-1:0] data_bus,
  output logic [3:0]          rd,
  output logic [3:0]          grant,
  output logic [3:0]          done,
  output logic [DATA_W-1:0]   result,
  output logic                busy,
  output logic                err,
  output logic                acc_add_en,
  output logic [CNT_W-1:0]    acc_num,
  output logic [DATA_W-1:0]   acc_data,
  input  logic [DATA_W-1:0]   acc_sum,
  input  logic                acc_add_end
);

  // WAIT-cycle counter runs 0 .. TO_CYC-1; reaching the last value without an
  // end flag is the timeout.
  localparam int              TO_W    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_ptr;
  logic [1:0]        r_owner;
  logic [CNT_W-1:0]  r_cnt;
  logic [TO_W-1:0]   r_to;
  logic [3:0]        r_rd;
  logic [3:0]        r_grant;
  logic [3:0]        r_done;
  logic [DATA_W-1:0] r_result;
  logic              r_busy;
  logic              r_err;
  logic              r_add_en;
  logic [CNT_W-1:0]  r_acc_num;

  logic [2:0]        w_pick;
  logic [3:0]        w_grant_nxt;
  logic              w_end_ok;
  logic              w_timeout;
  logic [DATA_W-1:0] w_acc_data;

  // Round-robin search: returns {found, index}. Offsets are scanned from the
  // farthest (the pointer itself) to the nearest (pointer+1) so that the
  // nearest set request is the one left in the result.
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] rq);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (rq[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state and next-grant decode.
  always_comb begin
    w_pick      = rr_pick(r_ptr, req);
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_end_ok    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick[2]) begin
          w_state_nxt = S_LAUNCH;
          w_grant_nxt = 4'b0001 << w_pick[1:0];
        end else begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = 4'b0000;
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // r_cnt starts at acc_num, so RUN lasts acc_num+1 cycles.
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_WAIT: begin
        if (acc_add_end) begin
          w_state_nxt = S_DONE;
          w_end_ok    = 1'b1;
        end else if (r_to == TO_LAST) begin
          w_state_nxt = S_DONE;
          w_timeout   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
      end
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered Moore outputs, decoded from the state being entered so each
  // one lines up exactly with its state.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_grant  <= 4'b0000;
      r_rd     <= 4'b0000;
      r_done   <= 4'b0000;
      r_busy   <= 1'b0;
      r_add_en <= 1'b0;
    end else begin
      r_grant  <= w_grant_nxt;
      r_rd     <= (w_state_nxt == S_RUN)  ? w_grant_nxt : 4'b0000;
      r_done   <= (w_state_nxt == S_DONE) ? w_grant_nxt : 4'b0000;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_add_en <= (w_state_nxt == S_LAUNCH);
    end
  end

  // Transaction datapath: owner capture, sample and timeout counters, result,
  // sticky error and round-robin pointer.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_ptr     <= 2'd3;
      r_owner   <= 2'd0;
      r_cnt     <= {CNT_W{1'b0}};
      r_to      <= {TO_W{1'b0}};
      r_result  <= {DATA_W{1'b0}};
      r_err     <= 1'b0;
      r_acc_num <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick[2]) begin
            r_owner   <= w_pick[1:0];
            r_acc_num <= num_bus[w_pick[1:0]*CNT_W +: CNT_W];
          end
        end
        S_LAUNCH: begin
          r_cnt <= r_acc_num;
          r_to  <= {TO_W{1'b0}};
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_WAIT: begin
          r_to <= r_to + TO_W'(1);
          if (w_end_ok) begin
            r_result <= acc_sum;
          end
          if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        S_DONE: begin
          r_ptr <= r_owner;
          r_to  <= {TO_W{1'b0}};
        end
        default: begin
          r_to <= {TO_W{1'b0}};
        end
      endcase
    end
  end

  // Owner's data word steered to the accumulator; zero when nobody owns it.
  always_comb begin
    case (r_grant)
      4'b0001: w_acc_data = data_bus[0*DATA_W +: DATA_W];
      4'b0010: w_acc_data = data_bus[1*DATA_W +: DATA_W];
      4'b0100: w_acc_data = data_bus[2*DATA_W +: DATA_W];
      4'b1000: w_acc_data = data_bus[3*DATA_W +: DATA_W];
      default: w_acc_data = {DATA_W{1'b0}};
    endcase
  end

  assign rd         = r_rd;
  assign grant      = r_grant;
  assign done       = r_done;
  assign result     = r_result;
  assign busy       = r_busy;
  assign err        = r_err;
  assign acc_add_en = r_add_en;
  assign acc_num    = r_acc_num;
  assign acc_data   = w_acc_data;

endmodule

// File: tb/tb_acc_share_ctrl.sv
// Self-checking bench for acc_share_ctrl: behavioural accumulator, requester
// data streams, scoreboard of expected completions and a negedge monitor.
module tb_acc_share_ctrl;

  logic        sys_clk;
  logic        sys_rst;
  logic [3:0]  req;
  logic [15:0] num_bus;
  logic [31:0] data_bus;
  logic [3:0]  rd;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  result;
  logic        busy;
  logic        err;
  logic        acc_add_en;
  logic [3:0]  acc_num;
  logic [7:0]  acc_data;
  logic [7:0]  acc_sum;
  logic        acc_add_end;

  acc_share_ctrl #(.DATA_W(8), .CNT_W(4), .TO_CYC(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .req        (req),
    .num_bus    (num_bus),
    .data_bus   (data_bus),
    .rd         (rd),
    .grant      (grant),
    .done       (done),
    .result     (result),
    .busy       (busy),
    .err        (err),
    .acc_add_en (acc_add_en),
    .acc_num    (acc_num),
    .acc_data   (acc_data),
    .acc_sum    (acc_sum),
    .acc_add_end(acc_add_end)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] dn;
    logic [7:0] res;
    logic       er;
    int         rds;
    int         lat;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] dn, input logic [7:0] res, input logic er,
                          input int rds, input int lat);
    exp_t e;
    e.dn = dn; e.res = res; e.er = er; e.rds = rds; e.lat = lat;
    sb_q.push_back(e);
  endtask

  // ---------------- requesters: data tables with per-requester read pointer
  logic [7:0] dmem [4][16];
  logic [3:0] rp   [4];

  always @(posedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!sys_rst)      rp[i] <= 4'd0;
      else if (done[i])  rp[i] <= 4'd0;
      else if (rd[i])    rp[i] <= rp[i] + 4'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) data_bus[i*8 +: 8] = dmem[i][rp[i]];
  end

  // ---------------- behavioural accumulator (mode 1 = never finishes)
  logic       acc_mode;
  logic       spur;
  logic [7:0] spur_val;
  logic       m_act;
  int         m_rem;
  logic [7:0] m_sum;
  logic [7:0] m_sum_n;
  logic       m_end;
  logic [7:0] m_out;

  assign m_sum_n     = m_sum + acc_data;
  assign acc_add_end = m_end | spur;
  assign acc_sum     = spur ? spur_val : m_out;

  always @(posedge sys_clk) begin
    if (!sys_rst) begin
      m_act <= 1'b0; m_rem <= 0; m_sum <= 8'd0; m_end <= 1'b0; m_out <= 8'd0;
    end else begin
      m_end <= 1'b0;
      if (acc_add_en) begin
        m_act <= 1'b1;
        m_rem <= int'(acc_num) + 1;
        m_sum <= 8'd0;
      end else if (m_act) begin
        m_sum <= m_sum_n;
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_act <= 1'b0;
          if (!acc_mode) begin
            m_end <= 1'b1;
            m_out <= m_sum_n;
          end
        end
      end
    end
  end

  // ---------------- monitor: per-cycle invariants and scoreboard pop on done
  int cyc       = 0;
  int t_launch  = 0;
  int rd_cnt    = 0;

  initial begin
    exp_t e;
    int   own;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (!sys_rst) begin
        rd_cnt = 0;
      end else begin
        check("grant_onehot", int'($countones(grant) <= 1), 1);
        if (acc_add_en) t_launch = cyc;
        if (rd != 4'b0000) begin
          rd_cnt++;
          own = 0;
          for (int i = 0; i < 4; i++) if (rd[i]) own = i;
          check("rd_vs_grant", int'(rd), int'(grant));
          check("acc_data", int'(acc_data), int'(dmem[own][rp[own]]));
        end
        if (done != 4'b0000) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", int'(done), 0);
          end else begin
            e = sb_q.pop_front();
            check("done_owner", int'(done), int'(e.dn));
            check("result", int'(result), int'(e.res));
            check("err", int'(err), int'(e.er));
            check("rd_cycles", rd_cnt, e.rds);
            check("launch_to_done", cyc - t_launch, e.lat);
          end
          rd_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  // ---------------- stimulus
  task automatic wait_done(input int limit);
    bit got;
    got = 1'b0;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge sys_clk);
      if (done != 4'b0000) got = 1'b1;
    end
    check("done_arrived", int'(got), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},     int'(rd), 0);
    check({tag, "_grant"},  int'(grant), 0);
    check({tag, "_done"},   int'(done), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_busy"},   int'(busy), 0);
    check({tag, "_err"},    int'(err), 0);
    check({tag, "_adden"},  int'(acc_add_en), 0);
    check({tag, "_accnum"}, int'(acc_num), 0);
    check({tag, "_accdat"}, int'(acc_data), 0);
  endtask

  initial begin
    bit found;
    sys_rst  = 1'b0;
    req      = 4'b0000;
    num_bus  = 16'h0000;
    acc_mode = 1'b0;
    spur     = 1'b0;
    spur_val = 8'h00;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 16; j++) dmem[i][j] = 8'h00;

    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single burst: 1+2+3+4 = 10, add_en one cycle after the request edge.
    dmem[0][0] = 8'd1; dmem[0][1] = 8'd2; dmem[0][2] = 8'd3; dmem[0][3] = 8'd4;
    num_bus[3:0] = 4'd3;
    push_exp(4'b0001, 8'd10, 1'b0, 4, 6);
    req = 4'b0001;
    @(negedge sys_clk);
    check("t1_adden_hi", int'(acc_add_en), 1);
    check("t1_launch_busy", int'(busy), 1);
    @(negedge sys_clk);
    check("t1_adden_lo", int'(acc_add_en), 0);
    check("t1_rd_first", int'(rd), 1);
    wait_done(60);
    req = 4'b0000;

    // Minimum count: one sample.
    dmem[2][0] = 8'h5A;
    num_bus[11:8] = 4'd0;
    push_exp(4'b0100, 8'h5A, 1'b0, 1, 3);
    req = 4'b0100;
    wait_done(60);
    req = 4'b0000;

    // Wrap: 16 x 0x20 = 0x200 -> 0x00.
    for (int j = 0; j < 16; j++) dmem[3][j] = 8'h20;
    num_bus[15:12] = 4'd15;
    push_exp(4'b1000, 8'h00, 1'b0, 16, 18);
    req = 4'b1000;
    wait_done(60);
    req = 4'b0000;

    // Round robin, all requesting, two samples each: order 0,1,2,3,0.
    dmem[0][0] = 8'h01; dmem[0][1] = 8'h02;
    dmem[1][0] = 8'h10; dmem[1][1] = 8'h11;
    dmem[2][0] = 8'h30; dmem[2][1] = 8'h31;
    dmem[3][0] = 8'h80; dmem[3][1] = 8'h90;
    num_bus = 16'h1111;
    push_exp(4'b0001, 8'h03, 1'b0, 2, 4);
    push_exp(4'b0010, 8'h21, 1'b0, 2, 4);
    push_exp(4'b0100, 8'h61, 1'b0, 2, 4);
    push_exp(4'b1000, 8'h10, 1'b0, 2, 4);
    push_exp(4'b0001, 8'h03, 1'b0, 2, 4);
    req = 4'b1111;
    repeat (5) wait_done(60);
    req = 4'b0000;

    // End flag outside WAIT is ignored.
    @(negedge sys_clk);
    spur_val = 8'hEE;
    spur     = 1'b1;
    @(negedge sys_clk);
    spur     = 1'b0;
    @(negedge sys_clk);
    check("spur_result", int'(result), 8'h03);
    check("spur_err", int'(err), 0);
    check("spur_busy", int'(busy), 0);

    // Timeout: accumulator never ends; result kept, err set.
    acc_mode = 1'b1;
    dmem[0][0] = 8'd1; dmem[0][1] = 8'd2; dmem[0][2] = 8'd3;
    num_bus[3:0] = 4'd2;
    push_exp(4'b0001, 8'h03, 1'b1, 3, 12);
    req = 4'b0001;
    wait_done(60);
    req = 4'b0000;
    acc_mode = 1'b0;

    // Next transaction completes normally; err stays set.
    dmem[1][0] = 8'h77;
    num_bus[7:4] = 4'd0;
    push_exp(4'b0010, 8'h77, 1'b1, 1, 3);
    req = 4'b0010;
    wait_done(60);
    req = 4'b0000;
    repeat (2) @(negedge sys_clk);
    check("err_sticky", int'(err), 1);

    // Reset on the second RUN cycle of a six-sample burst.
    num_bus[3:0] = 4'd5;
    req = 4'b0001;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge sys_clk);
      if (rd != 4'b0000) found = 1'b1;
    end
    check("rst_run_reached", int'(found), 1);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check_all_zero("midrst");
    req = 4'b0010;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    push_exp(4'b0010, 8'h77, 1'b0, 1, 3);
    wait_done(60);
    req = 4'b0000;

    repeat (5) @(negedge sys_clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_share_ctrl.md
Name: acc_share_ctrl

Overview:
- Round-robin scheduler that shares one 8-bit burst accumulator between 4 requesters.
- The accumulator takes a one-cycle start pulse plus a sample count. It sums num+1 consecutive data words and returns the sum with a one-cycle end flag.
- This block sequences each transaction end to end: picks a requester, launches the accumulator, streams that requester's data with a read strobe, and captures the sum. It then returns the sum to the requester with a done pulse, and flags an error if the accumulator never finishes.

Parameters:
- DATA_W, 8, data and sum width; must match the accumulator.
- CNT_W, 4, sample-count width; the accumulator sums num+1 samples, 1..16.
- TO_CYC, 8, cycles allowed after the last sample before a missing end flag counts as an error.

Ports:
- sys_clk  in  1  single clock; all logic on the rising edge.
- sys_rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- req  in  4  request per requester; level, held until the matching done.
- num_bus  in  4*CNT_W  per-requester count; requester i uses [i*CNT_W +: CNT_W].
- data_bus  in  4*DATA_W  per-requester data word; slice i must be valid in any cycle where rd[i]=1.
- rd  out  4  one-hot strobe; the accumulator samples the granted slice this cycle, so the requester advances to its next word.
- grant  out  4  one-hot owner; held from LAUNCH through DONE, 0 in IDLE.
- done  out  4  one-cycle pulse to the owner when the transaction ends.
- result  out  DATA_W  sum of the last completed transaction; held until the next completion.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag; cleared only by reset.
- acc_add_en  out  1  start pulse to the accumulator.
- acc_num  out  CNT_W  count to the accumulator.
- acc_data  out  DATA_W  data to the accumulator.
- acc_sum  in  DATA_W  accumulator sum.
- acc_add_end  in  1  accumulator end flag; acc_sum is valid in that cycle.

Behaviour:
- Reset values: all outputs 0, state IDLE, RR pointer = 3 (requester 0 has top priority after reset).
- FSM states: IDLE, LAUNCH, RUN, WAIT, DONE.
- IDLE:
  - If req != 0, the winner is the first set bit searching from pointer+1 upward, wrapping modulo 4.
  - At that edge: grant[w] set, acc_num <= num_bus slice w, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - acc_add_en = 1, registered, high only in this state.
  - Sample counter loaded with acc_num; go to RUN.
- RUN (exactly acc_num+1 cycles):
  - rd[w] = 1 every cycle.
  - acc_data = data_bus slice w, combinational mux on grant; acc_data = 0 when grant = 0.
  - Counter decrements each cycle; leave for WAIT when the counter is 0.
- WAIT:
  - When acc_add_end = 1: result <= acc_sum, go to DONE.
  - Normal case: acc_add_end arrives in the first WAIT cycle.
  - Timeout: if TO_CYC WAIT cycles pass without acc_add_end, set err = 1, leave result unchanged, go to DONE.
- DONE (1 cycle):
  - done[w] = 1.
  - At the edge: pointer <= w, grant cleared, go to IDLE.
- Latency, with the request seen in IDLE cycle t:
  - acc_add_en high in cycle t+1.
  - rd high in cycles t+2 .. t+2+num.
  - acc_add_end expected in cycle t+3+num.
  - done in cycle t+4+num.
  - Earliest next LAUNCH in cycle t+6+num.
- acc_num is held constant from LAUNCH through DONE; the accumulator compares against it continuously.
- acc_add_en is never asserted outside LAUNCH, so the accumulator is never restarted while busy.
- Arithmetic: no widening; the sum wraps modulo 2^DATA_W, computed by the accumulator and passed through unchanged.
- req and num_bus changes after the grant are ignored until DONE; a requester dropping req mid-transaction still receives its done.
- acc_add_end while not in WAIT is ignored; it does not touch result or err.
- Reset mid-transaction: all registers return to reset values asynchronously and no done is issued. The accumulator shares sys_rst, so no cleanup is required.

Test Plan:
- Single burst: req=0001, num0=3, data0 sequence 1,2,3,4, accumulator model normal → acc_add_en one cycle at t+1; rd[0] for 4 cycles; done[0] at t+7; result=10; err=0.
- Minimum count: req=0100, num2=0, data2=0x5A → rd[2] exactly 1 cycle; result=0x5A; done[2] at t+4.
- Wrap: req=1000, num3=15, data3 constant 0x20 → 16 rd cycles; result=0x00 (0x200 mod 256).
- Round robin: req=1111 held high, each num=1 → grant order 0,1,2,3,0; one done per transaction; grant never has 2 bits set.
- Timeout: accumulator model never raises acc_add_end, num0=2 → err=1 after 8 WAIT cycles; done[0] pulses; result unchanged; err stays 1 across later transactions until reset.
- Reset mid-RUN: deassert sys_rst at the 2nd rd cycle of num=5 → all outputs 0 immediately; no done. After release, req=0010 is served first by requester 1, with requester 0 first only if it is also requesting.
